uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with a configurable frame format, error detection and an output FIFO.

---
 rtl/uart_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, sticky line-error flags and a
// show-ahead byte FIFO drained by the downstream parser at its own pace.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          serial_data_in,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  input  logic                          err_clr,
  output logic                          rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   stop_bad_q, stop_bad_d, par_bad_q, par_bad_d;
  logic                   wr_req_q, wr_req_d, fe_set_q, fe_set_d, pe_set_q, pe_set_d;
  logic                   sync1_q, rx_s_q, rx_prev_q;
  logic                   done, bit_tick;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
  logic                   pop, wr, full, ovr_set;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= serial_data_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    stop_bad_d = stop_bad_q;
    par_bad_d  = par_bad_q;
    done       = 1'b0;
    bit_tick   = (cnt_q == CNT_END);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = S_START;
      end
      S_START: if (cnt_q == CNT_MID) begin
        // Restarting the counter here puts every later sample at mid-bit.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
        else begin
          state_d    = S_DATA;
          bit_d      = '0;
          stop_bad_d = 1'b0;
          par_bad_d  = 1'b0;
        end
      end
      S_DATA: if (bit_tick) begin
        cnt_d   = '0;
        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == LAST_DATA) begin
          bit_d   = '0;
          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_tick) begin
        cnt_d     = '0;
        par_bad_d = ((^shreg_q) ^ rx_s_q) != (PARITY_MODE == 2);
        state_d   = S_STOP;
      end
      S_STOP: if (bit_tick) begin
        cnt_d      = '0;
        bit_d      = bit_q + 1'b1;
        stop_bad_d = stop_bad_q | ~rx_s_q;
        if (bit_q == LAST_STOP) begin
          done    = 1'b1;
          state_d = stop_bad_d ? S_WAIT_IDLE : S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wr_req_d = done & ~stop_bad_d & ~par_bad_q;
    fe_set_d = done & stop_bad_d;
    pe_set_d = done & par_bad_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      stop_bad_q <= 1'b0;
      par_bad_q  <= 1'b0;
      wr_req_q   <= 1'b0;
      fe_set_q   <= 1'b0;
      pe_set_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      stop_bad_q <= stop_bad_d;
      par_bad_q  <= par_bad_d;
      wr_req_q   <= wr_req_d;
      fe_set_q   <= fe_set_d;
      pe_set_q   <= pe_set_d;
    end
  end

  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  always_comb begin
    pop      = rd_en & rd_valid;
    full     = (count_q == CNT_FULL);
    wr       = wr_req_q & (~full | pop);
    ovr_set  = wr_req_q & full & ~pop;
    wr_ptr_d = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (!wr && pop) count_d = count_q - 1'b1;
    fe_d = fe_set_q | (fe_q & ~err_clr);
    pe_d = pe_set_q | (pe_q & ~err_clr);
    ov_d = ovr_set  | (ov_q & ~err_clr);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
      ov_q     <= ov_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign framing_err = fe_q;
  assign parity_err  = pe_q;
  assign overrun_err = ov_q;
  assign rx_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: an 8N1 depth-4 receiver and a 7E2 depth-16 receiver share
// clock and reset; directed frames push expected bytes, monitors check pops.
module tb_uart_rx_fifo;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       rx_a, rd_en_a, clr_a, rd_valid_a, fe_a, pe_a, ov_a, busy_a;
  logic [7:0] rd_data_a;
  logic [2:0] cnt_a;
  logic       rx_b, rd_en_b, clr_b, rd_valid_b, fe_b, pe_b, ov_b, busy_b;
  logic [6:0] rd_data_b;
  logic [4:0] cnt_b;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_a [$];
  logic [8:0] exp_b [$];
  logic strict_a = 1'b0;

  always #5 Clk = ~Clk;

  uart_rx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .serial_data_in(rx_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .fifo_count(cnt_a), .framing_err(fe_a), .parity_err(pe_a),
    .overrun_err(ov_a), .err_clr(clr_a), .rx_busy(busy_a));

  uart_rx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .Clk(Clk), .Reset(Reset), .serial_data_in(rx_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .fifo_count(cnt_b), .framing_err(fe_b), .parity_err(pe_b),
    .overrun_err(ov_b), .err_clr(clr_b), .rx_busy(busy_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
    repeat (8) tick();
  endtask

  // par < 0 means no parity bit on the wire
  task automatic send(input int which, input logic [8:0] data, input int nbits,
                      input int par, input int nstop, input logic stop_val);
    drive(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive(which, data[i]);
    if (par >= 0) drive(which, par[0]);
    for (int i = 0; i < nstop; i++) drive(which, stop_val);
  endtask

  task automatic wait_drain(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? exp_a.size() : exp_b.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check(which == 0 ? "drain_a" : "drain_b", (which == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_a = 1'b1;
    clr_b = 1'b1;
    tick();
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  task automatic mon_a();
    logic [8:0] e;
    forever begin
      @(negedge Clk);
      if (rd_en_a && rd_valid_a) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_a: unexpected byte 0x%0h", rd_data_a);
        end else begin
          e = exp_a.pop_front();
          check("data_a", rd_data_a, e);
          if (strict_a) check("count_a_at_pop", cnt_a, 1);
        end
      end
    end
  endtask

  task automatic mon_b();
    logic [8:0] e;
    forever begin
      @(negedge Clk);
      if (rd_en_b && rd_valid_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_b: unexpected byte 0x%0h", rd_data_b);
        end else begin
          e = exp_b.pop_front();
          check("data_b", rd_data_b, e);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] gll [6];
    gll = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h4C, 8'h4C};
    Reset = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    fork
      mon_a();
      mon_b();
    join_none
    repeat (3) tick();
    check("rst_valid", {rd_valid_a, rd_valid_b}, 0);
    check("rst_count", {cnt_a, cnt_b}, 0);
    check("rst_flags", {fe_a, pe_a, ov_a, fe_b, pe_b, ov_b}, 0);
    check("rst_busy", {busy_a, busy_b}, 0);
    check("rst_data", {rd_data_a, rd_data_b}, 0);
    Reset = 1'b0;
    repeat (4) tick();

    // back-to-back NMEA bytes with the reader always ready
    rd_en_a = 1'b1;
    strict_a = 1'b1;
    foreach (gll[i]) exp_a.push_back({1'b0, gll[i]});
    foreach (gll[i]) send(0, {1'b0, gll[i]}, 8, -1, 1, 1'b1);
    wait_drain(0, 200);
    check("t1_flags", {fe_a, pe_a, ov_a}, 0);

    // 3-clock glitch: a false start, nothing stored
    rx_a = 1'b0;
    repeat (3) tick();
    check("t5_busy_during", busy_a, 1);
    rx_a = 1'b1;
    repeat (20) tick();
    check("t5_busy_after", busy_a, 0);
    check("t5_count", cnt_a, 0);
    check("t5_flags", {fe_a, pe_a, ov_a}, 0);

    // stop bit low, line held low, then a clean frame
    send(0, 9'h055, 8, -1, 1, 1'b0);
    repeat (80) tick();
    check("t3_wait_idle_busy", busy_a, 1);
    repeat (80) tick();
    rx_a = 1'b1;
    repeat (16) tick();
    check("t3_framing", fe_a, 1);
    check("t3_busy_released", busy_a, 0);
    exp_a.push_back(9'h033);
    send(0, 9'h033, 8, -1, 1, 1'b1);
    wait_drain(0, 200);
    pulse_clr();
    check("t3_framing_clr", fe_a, 0);

    // overrun: five bytes into a four-entry FIFO with no reads
    rd_en_a = 1'b0;
    strict_a = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 9'(8'h11 + i), 8, -1, 1, 1'b1);
    repeat (16) tick();
    check("t4_count", cnt_a, 4);
    check("t4_overrun", ov_a, 1);
    check("t4_head", rd_data_a, 8'h11);
    for (int i = 0; i < 4; i++) exp_a.push_back(9'(8'h11 + i));
    pulse_clr();
    check("t4_overrun_clr", ov_a, 0);
    rd_en_a = 1'b1;
    wait_drain(0, 50);
    repeat (2) tick();
    check("t4_count_empty", cnt_a, 0);

    // 7E2: good parity then bad parity
    rd_en_b = 1'b1;
    exp_b.push_back(9'h041);
    send(1, 9'h041, 7, 0, 2, 1'b1);
    send(1, 9'h041, 7, 1, 2, 1'b1);
    repeat (16) tick();
    wait_drain(1, 100);
    check("t2_parity", pe_b, 1);
    check("t2_framing", fe_b, 0);
    check("t2_count", cnt_b, 0);

    // reset mid-frame: stored byte and partial frame are both lost
    rd_en_a = 1'b0;
    send(0, 9'h077, 8, -1, 1, 1'b1);
    repeat (8) tick();
    check("t6_prefill", cnt_a, 1);
    drive(0, 1'b0);
    drive(0, 1'b1); drive(0, 1'b0); drive(0, 1'b1); drive(0, 1'b0);
    rx_a = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    rx_a = 1'b1;
    tick();
    check("t6_busy_in_rst", busy_a, 0);
    check("t6_count_in_rst", cnt_a, 0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (16) tick();
    check("t6_idle_after_rst", busy_a, 0);
    rd_en_a = 1'b1;
    strict_a = 1'b1;
    exp_a.push_back(9'h05A);
    send(0, 9'h05A, 8, -1, 1, 1'b1);
    wait_drain(0, 100);
    repeat (2) tick();
    check("t6_flags", {fe_a, pe_a, ov_a}, 0);
    check("t6_count", cnt_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
